// File: rtl/shift_ex_stage.sv
// rtl/shift_ex_stage.sv - two-stage pipelined MIPS shift execute unit
// Logical right shifter core plus left/arithmetic fix-up, valid/ready flow control and op counter.

module shifter (
    output logic [31:0] res,
    input  logic [31:0] a,
    input  logic [4:0]  b
);
    assign res = a >> b;
endmodule

module shift_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [4:0]       in_shamt,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] T_LEFT   = 2'd0;
    localparam logic [1:0] T_LRIGHT = 2'd1;
    localparam logic [1:0] T_ARITH  = 2'd2;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    logic             s1_valid_q;
    logic [1:0]       s1_type_q, s1_type_d;
    logic [4:0]       s1_amt_q, s1_amt_d;
    logic [31:0]      s1_rt_q;
    logic [4:0]       s1_rd_q;
    logic             s1_ill_q, s1_ill_d;
    logic             out_valid_q;
    logic [31:0]      out_result_q, out_result_d;
    logic [4:0]       out_rd_q;
    logic             out_ill_q;
    logic [CNT_W-1:0] op_count_q;

    logic s2_adv, s1_adv, in_fire, out_fire, use_rs;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        s1_type_d = T_LEFT;
        s1_ill_d  = 1'b0;
        use_rs    = 1'b0;
        case (in_funct)
            6'h00: s1_type_d = T_LEFT;
            6'h02: s1_type_d = T_LRIGHT;
            6'h03: s1_type_d = T_ARITH;
            6'h04: use_rs = 1'b1;
            6'h06: begin s1_type_d = T_LRIGHT; use_rs = 1'b1; end
            6'h07: begin s1_type_d = T_ARITH;  use_rs = 1'b1; end
            default: s1_ill_d = 1'b1;
        endcase
        s1_amt_d = use_rs ? in_rs[4:0] : in_shamt;
    end

    // Left shifts reuse the right shifter by reversing the operand and the result.
    logic [31:0] sh_a, sh_res, fill_res;
    assign sh_a = (s1_type_q == T_LEFT) ? bitrev(s1_rt_q) : s1_rt_q;

    shifter u_lr   (.res(sh_res),   .a(sh_a),         .b(s1_amt_q));
    shifter u_fill (.res(fill_res), .a(32'hFFFFFFFF), .b(s1_amt_q));

    always_comb begin
        out_result_d = sh_res;
        if (s1_ill_q) begin
            out_result_d = 32'h0;
        end else if (s1_type_q == T_LEFT) begin
            out_result_d = bitrev(sh_res);
        end else if (s1_type_q == T_ARITH) begin
            out_result_d = sh_res | (s1_rt_q[31] ? ~fill_res : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_type_q    <= T_LEFT;
            s1_amt_q     <= 5'd0;
            s1_rt_q      <= 32'h0;
            s1_rd_q      <= 5'd0;
            s1_ill_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'h0;
            out_rd_q     <= 5'd0;
            out_ill_q    <= 1'b0;
        end else if (flush) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_type_q <= s1_type_d;
                s1_amt_q  <= s1_amt_d;
                s1_rt_q   <= in_rt;
                s1_rd_q   <= in_rd;
                s1_ill_q  <= s1_ill_d;
            end
            if (s2_adv) out_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                out_result_q <= out_result_d;
                out_rd_q     <= s1_rd_q;
                out_ill_q    <= s1_ill_q;
            end
        end
    end

    // A flushed result never transfers, so it is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (cnt_clr) begin
            op_count_q <= '0;
        end else if (out_fire && !flush && !(&op_count_q)) begin
            op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_ill_q;
    assign op_count    = op_count_q;
endmodule
